// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture block: entry layout and width helpers.
// With TRACE_DISPLAY_EN defined, a hex formatting helper for the trace printout is also provided.
`define TRACE_ENTRY_T(NC, WD, TW) \
    struct packed { \
        logic [(TW)-1:0]       tick; \
        logic [(NC)-1:0]       mask; \
        logic [(NC)*(WD)-1:0]  data; \
    }

package trace_pkg;

    localparam int unsigned NCHAN_DEF  = 6;
    localparam int unsigned W_DEF      = 8;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned TICK_W_DEF = 16;

    function automatic int unsigned entry_w(
        input int unsigned nchan,
        input int unsigned w,
        input int unsigned tick_w
    );
        return tick_w + nchan + nchan * w;
    endfunction

`ifdef TRACE_DISPLAY_EN
    function automatic string hex2(input logic [7:0] v, input logic chg);
        return chg ? $sformatf("%02h", v) : "~~";
    endfunction
`endif

endpackage

// File: rtl/trace_fifo.sv
// Circular entry buffer with show-ahead read and optional overwrite-oldest on full.
// drop pulses whenever an entry (incoming or oldest) is lost.
module trace_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WIDTH     = 8,
    parameter bit          OVERWRITE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;
    logic             evict;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer accepts a push only if a slot frees this cycle or old data may be evicted.
    assign do_push = push && (!full || do_pop || OVERWRITE);
    assign evict   = push && full && !do_pop && OVERWRITE;
    assign drop    = push && full && !do_pop;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop || evict) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop && !evict) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Register-channel change monitor feeding a drainable circular trace buffer.
// Define TRACE_DISPLAY_EN for a simulation-only printout of recorded entries.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned NCHAN       = NCHAN_DEF,
    parameter int unsigned W           = W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned TICK_W      = TICK_W_DEF,
    parameter bit          CHANGE_ONLY = 1'b1,
    parameter bit          OVERWRITE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCHAN*W-1:0]      chan_in,
    input  logic                    enable,
    input  logic [TICK_W-1:0]       step_limit,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [NCHAN*W-1:0]      rd_data,
    output logic [NCHAN-1:0]        rd_mask,
    output logic [TICK_W-1:0]       rd_tick,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    done
);

    localparam int unsigned EW = entry_w(NCHAN, W, TICK_W);

    typedef `TRACE_ENTRY_T(NCHAN, W, TICK_W) entry_t;

    logic [TICK_W-1:0]  tick;
    logic [NCHAN*W-1:0] prev;
    logic               prev_valid;
    logic [NCHAN-1:0]   mask;
    logic               capture;
    logic               rec;
    logic               limit_hit;
    entry_t             wentry;
    entry_t             rentry;
    logic [EW-1:0]      rvec;
    logic               full;
    logic               empty;
    logic               drop;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NCHAN; i++) begin
            mask[i] = !prev_valid || (chan_in[i*W +: W] != prev[i*W +: W]);
        end
    end

    assign capture   = enable && !done;
    assign rec       = capture && ((mask != '0) || !CHANGE_ONLY);
    // Compared on the wrapped tick, so a limit of 1 stops right after tick 0.
    assign limit_hit = (step_limit != '0) && (tick == step_limit - TICK_W'(1));

    always_comb begin
        wentry      = '0;
        wentry.tick = tick;
        wentry.mask = mask;
        wentry.data = chan_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick       <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (!done) begin
                tick <= tick + TICK_W'(1);
            end
            if (capture) begin
                prev       <= chan_in;
                prev_valid <= 1'b1;
            end
            if (!done && limit_hit) begin
                done <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (EW),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rec),
        .pop   (rd_ready),
        .wdata (wentry),
        .rdata (rvec),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    assign rentry   = rvec;
    assign rd_valid = !empty;
    assign rd_data  = rentry.data;
    assign rd_mask  = rentry.mask;
    assign rd_tick  = rentry.tick;

`ifdef TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (rec) begin
                string s;
                s = $sformatf("%4d ", tick);
                for (int i = 0; i < NCHAN; i++) begin
                    s = {s, " ", hex2(8'(chan_in[i*W +: W]), mask[i])};
                end
                $display("%s", s);
            end
            if (drop) begin
                $display("TRACE OVERFLOW");
            end
        end
    end
`endif

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench: an overwrite and a drop-incoming instance, both DEPTH=4, share stimulus.
module tb_trace_capture;

    localparam int NCHAN = 6;
    localparam int W     = 8;
    localparam int TW    = 16;

    logic              clk;
    logic              reset;
    logic [NCHAN*W-1:0] chan_in;
    logic              enable;
    logic [TW-1:0]     step_limit;
    logic              rd_ready;

    logic              a_rd_valid, b_rd_valid;
    logic [NCHAN*W-1:0] a_rd_data, b_rd_data;
    logic [NCHAN-1:0]  a_rd_mask, b_rd_mask;
    logic [TW-1:0]     a_rd_tick, b_rd_tick;
    logic [2:0]        a_count, b_count;
    logic              a_overflow, b_overflow;
    logic              a_done, b_done;

    int checks = 0;
    int failures = 0;

    trace_capture #(
        .NCHAN(NCHAN), .W(W), .DEPTH(4), .TICK_W(TW),
        .CHANGE_ONLY(1'b1), .OVERWRITE(1'b1)
    ) u_a (
        .clk(clk), .reset(reset), .chan_in(chan_in), .enable(enable),
        .step_limit(step_limit), .rd_valid(a_rd_valid), .rd_ready(rd_ready),
        .rd_data(a_rd_data), .rd_mask(a_rd_mask), .rd_tick(a_rd_tick),
        .count(a_count), .overflow(a_overflow), .done(a_done)
    );

    trace_capture #(
        .NCHAN(NCHAN), .W(W), .DEPTH(4), .TICK_W(TW),
        .CHANGE_ONLY(1'b1), .OVERWRITE(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .chan_in(chan_in), .enable(enable),
        .step_limit(step_limit), .rd_valid(b_rd_valid), .rd_ready(rd_ready),
        .rd_data(b_rd_data), .rd_mask(b_rd_mask), .rd_tick(b_rd_tick),
        .count(b_count), .overflow(b_overflow), .done(b_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        enable     = 1'b0;
        chan_in    = '0;
        step_limit = '0;
        rd_ready   = 1'b0;
        step();

        // reset state
        chk("rst_valid", 64'(a_rd_valid), 64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_ovf", 64'(a_overflow), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_tick", 64'(a_rd_tick), 64'd0);
        chk("rst_data", 64'(a_rd_data), 64'd0);
        chk("rst_mask", 64'(a_rd_mask), 64'd0);

        // constant channels: only the first cycle records
        reset   = 1'b0;
        enable  = 1'b1;
        chan_in = {6{8'h11}};
        repeat (5) step();
        chk("t1_count", 64'(a_count), 64'd1);
        chk("t1_valid", 64'(a_rd_valid), 64'd1);
        chk("t1_tick", 64'(a_rd_tick), 64'd0);
        chk("t1_mask", 64'(a_rd_mask), 64'h3f);
        chk("t1_data", 64'(a_rd_data), 64'h1111_1111_1111);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t1_pop_count", 64'(a_count), 64'd0);
        chk("t1_pop_valid", 64'(a_rd_valid), 64'd0);

        // areg change at tick 3
        reset = 1'b1;
        step();
        reset         = 1'b0;
        chan_in       = '0;
        chan_in[15:8] = 8'h01;
        rd_ready      = 1'b1;
        step();
        chk("t2_empty_rdy", 64'(a_count), 64'd1);
        step();
        chk("t2_pop", 64'(a_count), 64'd0);
        step();
        chan_in[15:8] = 8'h02;
        rd_ready      = 1'b0;
        step();
        chk("t2_count", 64'(a_count), 64'd1);
        chk("t2_tick", 64'(a_rd_tick), 64'd3);
        chk("t2_mask", 64'(a_rd_mask), 64'h02);
        chk("t2_data", 64'(a_rd_data), 64'h0000_0000_0200);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t2_drained", 64'(a_rd_valid), 64'd0);

        // six changing cycles into a 4-deep buffer
        reset = 1'b1;
        step();
        reset   = 1'b0;
        chan_in = '0;
        for (int k = 0; k < 6; k++) begin
            chan_in[7:0] = 8'(k + 1);
            step();
            if (k == 3) begin
                chk("t3_full_cnt", 64'(a_count), 64'd4);
                chk("t3_full_ovf", 64'(a_overflow), 64'd0);
                chk("t4_full_ovf", 64'(b_overflow), 64'd0);
            end
        end
        enable = 1'b0;
        chk("t3_count", 64'(a_count), 64'd4);
        chk("t3_ovf", 64'(a_overflow), 64'd1);
        chk("t4_count", 64'(b_count), 64'd4);
        chk("t4_ovf", 64'(b_overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_tick%0d", i), 64'(a_rd_tick), 64'(2 + i));
            chk($sformatf("t4_tick%0d", i), 64'(b_rd_tick), 64'(i));
            chk($sformatf("t4_pc%0d", i), 64'(b_rd_data[7:0]), 64'(i + 1));
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        chk("t3_empty", 64'(a_count), 64'd0);
        chk("t4_empty", 64'(b_count), 64'd0);

        // full buffer with simultaneous record and pop, then reset mid-run
        reset = 1'b1;
        step();
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chan_in[7:0] = 8'(8'h40 + k);
            step();
        end
        chan_in[7:0] = 8'h50;
        rd_ready     = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t6_a_count", 64'(a_count), 64'd4);
        chk("t6_b_count", 64'(b_count), 64'd4);
        chk("t6_a_ovf", 64'(a_overflow), 64'd0);
        chk("t6_b_ovf", 64'(b_overflow), 64'd0);
        chk("t6_a_tick", 64'(a_rd_tick), 64'd1);
        chk("t6_b_tick", 64'(b_rd_tick), 64'd1);
        chan_in[7:0] = 8'h55;
        step();
        chk("t6_ovf_set", 64'(a_overflow), 64'd1);
        chan_in[7:0] = 8'h60;
        reset        = 1'b1;
        step();
        chk("t6_rst_valid", 64'(a_rd_valid), 64'd0);
        chk("t6_rst_count", 64'(a_count), 64'd0);
        chk("t6_rst_ovf", 64'(a_overflow), 64'd0);
        chk("t6_rst_tick", 64'(a_rd_tick), 64'd0);
        chk("t6_rst_data", 64'(a_rd_data), 64'd0);
        chk("t6_rst_mask", 64'(a_rd_mask), 64'd0);
        chk("t6_rst_bcnt", 64'(b_count), 64'd0);
        reset = 1'b0;
        step();
        chk("t6_post_cnt", 64'(a_count), 64'd1);
        chk("t6_post_tick", 64'(a_rd_tick), 64'd0);
        chk("t6_post_mask", 64'(a_rd_mask), 64'h3f);

        // step limit 8 with a change every cycle
        reset = 1'b1;
        step();
        reset      = 1'b0;
        step_limit = 16'd8;
        for (int k = 0; k < 8; k++) begin
            chan_in[7:0] = 8'(8'h80 + k);
            step();
            if (k == 6) begin
                chk("t5_not_done", 64'(a_done), 64'd0);
            end
        end
        chk("t5_a_done", 64'(a_done), 64'd1);
        chk("t5_b_done", 64'(b_done), 64'd1);
        for (int k = 8; k < 10; k++) begin
            chan_in[7:0] = 8'(8'h80 + k);
            step();
        end
        chk("t5_count", 64'(a_count), 64'd4);
        chk("t5_b_ovf", 64'(b_overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_tick%0d", i), 64'(a_rd_tick), 64'(4 + i));
            chk($sformatf("t5_pc%0d", i), 64'(a_rd_data[7:0]), 64'(8'h84 + i));
            rd_ready = 1'b1;
            step();
        end
        rd_ready     = 1'b0;
        chan_in[7:0] = 8'hee;
        step();
        chan_in[7:0] = 8'hef;
        step();
        chk("t5_no_more", 64'(a_count), 64'd0);
        chk("t5_still_done", 64'(a_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
